port_bridge: RTL
================

PORT_BRIDGE -- requirements
Module: port_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth; power of two, 2..16.
REQ-002 SHALL have parameter DEB_CYCLES, default 3, consecutive stable cycles required before an input change is accepted; range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_port_out  input  4  drf_system port_output value.
REQ-006 SHALL have port cpu_port_in  output  4  conditioned value driven into drf_system port_input.
REQ-007 SHALL have port ext_in  input  4  asynchronous external input pins.
REQ-008 SHALL have port ext_data  output  4  FIFO head entry.
REQ-009 SHALL have port ext_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port ext_ready  input  1  external consumer accepts head.
REQ-011 SHALL have port fifo_full  output  1  occupancy equals DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky dropped-write flag.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL hold register prev (4 bit), loaded with cpu_port_out every cycle.
REQ-015 SHALL push cpu_port_out into the FIFO at any edge where cpu_port_out != prev; an unchanged value is never pushed.
REQ-016 SHALL keep FIFO occupancy as a counter of width log2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
REQ-017 SHALL drive ext_valid = (count != 0) and ext_data = entry at read pointer, both registered state with no combinational path from cpu_port_out.
REQ-018 SHALL pop at an edge where ext_valid && ext_ready; ext_data is don't-care while ext_valid is 0.
REQ-019 SHALL, on a push into an empty FIFO at edge N, assert ext_valid after edge N (1-cycle latency).
REQ-020 SHALL, on simultaneous push and pop, perform both with count unchanged, including when full.
REQ-021 SHALL, on push while full without pop, drop the value, leave FIFO contents unchanged, and set overflow.
REQ-022 SHALL clear overflow on ovf_clr; a drop in the same cycle takes priority and leaves overflow set.
REQ-023 SHALL synchronise ext_in through two flops (sync1, sync2) before any use.
REQ-024 SHALL, with debounce compiled in, run FSM STABLE/SETTLE with a counter: STABLE->SETTLE when sync2 != cpu_port_in; in SETTLE, counter increments while sync2 is unchanged from the previous cycle and restarts at 1 when sync2 changes; at counter == DEB_CYCLES load cpu_port_in <= sync2 and return to STABLE; sync2 == cpu_port_in in SETTLE returns to STABLE without update.

Reset
REQ-025 SHALL, while rst_n = 0, force prev, pointers, count, overflow, sync1, sync2, cpu_port_in, FSM (STABLE) and counter to zero; ext_valid = 0, fifo_full = 0.
REQ-026 SHALL abandon any in-progress SETTLE or FIFO contents on reset mid-operation; FIFO storage contents need not be cleared.
REQ-027 SHALL push cpu_port_out at the first edge after reset release if it is nonzero (prev = 0).

Configuration
REQ-028 SHALL compile the debounce FSM only when PORT_BRIDGE_DEBOUNCE_EN is defined; when undefined, cpu_port_in = sync2 registered, i.e. ext_in change visible at cpu_port_in after 2 edges, and DEB_CYCLES is ignored.

Verification
REQ-029 SHALL cover: cpu_port_out 0->5->5->A with ext_ready=0 -> count 2, ext_data=5, then ready=1 pops 5 then A, ext_valid drops after second pop.
REQ-030 SHALL cover: DEPTH=4, five distinct changes, ext_ready=0 -> fifo_full=1, fifth value dropped, overflow=1; ovf_clr -> overflow=0.
REQ-031 SHALL cover: full FIFO, change with ext_ready=1 same cycle -> count stays 4, head advances, overflow stays 0.
REQ-032 SHALL cover (debounce, DEB_CYCLES=3): ext_in 0->3 steady -> cpu_port_in=3 exactly 5 edges after change; glitch 0->3->0 lasting 1 cycle -> cpu_port_in stays 0.
REQ-033 SHALL cover: rst_n low mid-SETTLE with 2 FIFO entries -> all outputs 0 immediately, no push after release with cpu_port_out=0.
REQ-034 SHALL cover (macro undefined): ext_in 0->9 -> cpu_port_in=9 after 2 edges.

Source files
------------

// File: rtl/port_bridge.sv
// Bridge between drf_system's 4-bit port: output changes are queued for an external
// consumer; external pins are synchronised (and debounced when PORT_BRIDGE_DEBOUNCE_EN is defined).
module port_bridge #(
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cpu_port_out,
    output logic [3:0] cpu_port_in,
    input  logic [3:0] ext_in,
    output logic [3:0] ext_data,
    output logic       ext_valid,
    input  logic       ext_ready,
    output logic       fifo_full,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_param
        $error("port_bridge: DEPTH or DEB_CYCLES out of range");
    end

    logic [3:0]       prev_r;
    logic [3:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             valid_r;
    logic             full_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic             write_s;
    logic             drop_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;

    // FIFO control: a full FIFO still accepts a write when the head leaves in the same cycle
    always_comb begin
        push_s      = (cpu_port_out != prev_r);
        pop_s       = valid_r && ext_ready;
        write_s     = push_s && (!full_r || pop_s);
        drop_s      = push_s && full_r && !pop_s;
        count_nxt_s = count_r;
        if (write_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1'b1);
        end else if (pop_s && !write_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy, status flags and change detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r     <= 4'h0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            prev_r  <= cpu_port_out;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            full_r  <= (count_nxt_s == DEPTH_C);
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are meaningless while the occupancy is zero
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= cpu_port_out;
        end
    end

    assign ext_valid = valid_r;
    assign fifo_full = full_r;
    assign overflow  = overflow_r;
    assign ext_data  = valid_r ? mem_r[rd_ptr_r] : 4'h0;

    // Two-flop synchroniser for the asynchronous external pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'h0;
            sync2_r <= 4'h0;
        end else begin
            sync1_r <= ext_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PORT_BRIDGE_DEBOUNCE_EN
    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } deb_state_e;

    localparam logic [3:0] DEB_C = 4'(DEB_CYCLES);

    deb_state_e state_r;
    deb_state_e state_nxt_s;
    logic [3:0] deb_cnt_r;
    logic [3:0] deb_cnt_nxt_s;
    logic [3:0] cnt_inc_s;
    logic [3:0] sync2_d_r;
    logic [3:0] cpi_r;
    logic [3:0] cpi_nxt_s;

    // Debounce: accept a new pin value only after it has held for DEB_CYCLES cycles
    always_comb begin
        state_nxt_s   = state_r;
        deb_cnt_nxt_s = deb_cnt_r;
        cpi_nxt_s     = cpi_r;
        cnt_inc_s     = 4'd1;
        case (state_r)
            STABLE: begin
                if (sync2_r != cpi_r) begin
                    state_nxt_s   = SETTLE;
                    deb_cnt_nxt_s = 4'd1;
                end else begin
                    state_nxt_s   = STABLE;
                end
            end
            SETTLE: begin
                if (sync2_r == cpi_r) begin
                    state_nxt_s   = STABLE;
                    deb_cnt_nxt_s = 4'd0;
                end else begin
                    if (sync2_r == sync2_d_r) begin
                        cnt_inc_s = deb_cnt_r + 4'd1;
                    end else begin
                        cnt_inc_s = 4'd1;
                    end
                    if (cnt_inc_s >= DEB_C) begin
                        cpi_nxt_s     = sync2_r;
                        state_nxt_s   = STABLE;
                        deb_cnt_nxt_s = 4'd0;
                    end else begin
                        deb_cnt_nxt_s = cnt_inc_s;
                    end
                end
            end
            default: begin
                state_nxt_s   = STABLE;
                deb_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Debounce state, counter and accepted pin value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= STABLE;
            deb_cnt_r <= 4'd0;
            sync2_d_r <= 4'h0;
            cpi_r     <= 4'h0;
        end else begin
            state_r   <= state_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            sync2_d_r <= sync2_r;
            cpi_r     <= cpi_nxt_s;
        end
    end

    assign cpu_port_in = cpi_r;
`else
    assign cpu_port_in = sync2_r;
`endif

endmodule
